mem_port_arbiter: RTL and testbench

- Shares one single-ported main memory between the fetch (instruction) requester and the load/store (data) requester.
- Replaces the dual-port memory arrangement so the core runs on a single-port RAM.
- Issues at most one memory access per cycle, tracks one outstanding access with fixed latency, routes the response back to its owner, and produces stall-visible grants.
- Data has priority; an anti-starvation counter guarantees instruction forward progress.

---
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store requesters.
// Optional MEM_ARB_PERF_COUNTERS_EN adds saturating per-requester stall counters.
module mem_port_arbiter #(
    parameter int ADDRESS_BITS = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDRESS_BITS-1:0] i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDRESS_BITS-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]             perf_i_stall,
    output logic [31:0]             perf_d_stall
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state, state_n;
    logic [2:0] lat_cnt, lat_cnt_n;
    logic       owner, owner_n;
    logic [3:0] streak, streak_n;
    logic       done, free;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            owner   <= 1'b0;
            streak  <= '0;
        end else begin
            state   <= state_n;
            lat_cnt <= lat_cnt_n;
            owner   <= owner_n;
            streak  <= streak_n;
        end
    // owner: 1 = data requester; grants are gated by reset so nothing issues while held
    always_comb begin
        done      = state == BUSY && lat_cnt == 3'd1;
        free      = reset && (state == IDLE || done);
        d_gnt     = free && d_req && !(i_req && streak == 4'(MAX_D_STREAK));
        i_gnt     = free && i_req && !d_gnt;
        mem_en    = i_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = d_gnt ? d_addr : i_addr;
        mem_wdata = d_gnt ? d_wdata : '0;
        i_rvalid  = done && !owner;
        d_rvalid  = done && owner;
        i_rdata   = i_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        state_n   = mem_en ? BUSY : done ? IDLE : state;
        lat_cnt_n = mem_en ? 3'(MEM_LATENCY) : state == BUSY ? lat_cnt - 3'd1 : lat_cnt;
        owner_n   = mem_en ? d_gnt : owner;
        streak_n  = (!i_req || i_gnt) ? '0 :
                    (d_gnt && streak != 4'(MAX_D_STREAK)) ? streak + 4'd1 : streak;
    end
`ifdef MEM_ARB_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            perf_i_stall <= '0;
            perf_d_stall <= '0;
        end else begin
            if (i_req && !i_gnt && perf_i_stall != '1) perf_i_stall <= perf_i_stall + 32'd1;
            if (d_req && !d_gnt && perf_d_stall != '1) perf_d_stall <= perf_d_stall + 32'd1;
        end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter at MEM_LATENCY 1 (u1) and 3 (u3).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_i_req, a_i_gnt, a_i_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_mem_en, a_mem_we;
    logic [15:0] a_i_addr, a_d_addr, a_mem_addr;
    logic [31:0] a_i_rdata, a_d_wdata, a_d_rdata, a_mem_wdata, a_rd;
    logic        b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_en, b_mem_we;
    logic [15:0] b_i_addr, b_d_addr, b_mem_addr;
    logic [31:0] b_i_rdata, b_d_wdata, b_d_rdata, b_mem_wdata;
    logic [2:0][31:0] b_p;
    logic [31:0] mem1 [0:511];
    logic [31:0] mem3 [0:511];
    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_D_STREAK(4)) u1 (
        .clock(clk), .reset(reset),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_rd));

    mem_port_arbiter #(.MEM_LATENCY(3), .MAX_D_STREAK(4)) u3 (
        .clock(clk), .reset(reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_p[2]));

    // memory models: contents preloaded while reset is held, read data delayed by the latency
    always @(posedge clk) begin
        if (!reset) begin
            mem1[9'h004] <= 32'h00500093;
            mem3[9'h010] <= 32'hA0000010;
            mem3[9'h011] <= 32'hA0000011;
        end else begin
            if (a_mem_en && a_mem_we) mem1[a_mem_addr[8:0]] <= a_mem_wdata;
            if (b_mem_en && b_mem_we) mem3[b_mem_addr[8:0]] <= b_mem_wdata;
        end
        a_rd <= a_mem_en ? mem1[a_mem_addr[8:0]] : 32'h0;
        b_p  <= {b_p[1:0], b_mem_en ? mem3[b_mem_addr[8:0]] : 32'h0};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_i_req = 1'b1; a_i_addr = 16'h0004; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
        b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
        @(negedge clk);
        chk("rst_i_gnt", a_i_gnt, 0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_i_rdata", a_i_rdata, 0);
        chk("rst_d_rdata", a_d_rdata, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; a_i_req = 1'b0;
        @(negedge clk);
        chk("idle_i_gnt", a_i_gnt, 0);
        chk("idle_d_gnt", a_d_gnt, 0);
        chk("idle_i_rvalid", a_i_rvalid, 0);
        chk("idle_d_rvalid", a_d_rvalid, 0);
        chk("idle_mem_en", a_mem_en, 0);
        chk("idle_mem_we", a_mem_we, 0);
        chk("idle_b_mem_en", b_mem_en, 0);
        // single instruction read
        nxt(); a_i_req = 1'b1; a_i_addr = 16'h0004;
        @(negedge clk);
        chk("ird_i_gnt", a_i_gnt, 1);
        chk("ird_mem_en", a_mem_en, 1);
        chk("ird_mem_we", a_mem_we, 0);
        chk("ird_mem_addr", a_mem_addr, 32'h0004);
        nxt(); a_i_req = 1'b0;
        @(negedge clk);
        chk("ird_i_rvalid", a_i_rvalid, 1);
        chk("ird_i_rdata", a_i_rdata, 32'h00500093);
        chk("ird_d_rvalid", a_d_rvalid, 0);
        chk("ird_idle_gnt", a_i_gnt, 0);
        // data priority with a write
        nxt(); a_i_req = 1'b1; a_i_addr = 16'h0008;
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 16'h0100; a_d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("pri_d_gnt", a_d_gnt, 1);
        chk("pri_i_gnt", a_i_gnt, 0);
        chk("pri_mem_we", a_mem_we, 1);
        chk("pri_mem_addr", a_mem_addr, 32'h0100);
        chk("pri_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
        nxt(); a_d_req = 1'b0; a_d_we = 1'b0;
        @(negedge clk);
        chk("pri_d_rvalid", a_d_rvalid, 1);
        chk("pri_i_rvalid", a_i_rvalid, 0);
        chk("pri_i_gnt2", a_i_gnt, 1);
        chk("pri_mem_addr2", a_mem_addr, 32'h0008);
        nxt(); a_i_req = 1'b0; a_d_req = 1'b1; a_d_addr = 16'h0100;
        @(negedge clk);
        chk("wr_i_rvalid", a_i_rvalid, 1);
        chk("rb_d_gnt", a_d_gnt, 1);
        chk("rb_mem_we", a_mem_we, 0);
        nxt(); a_d_req = 1'b0;
        @(negedge clk);
        chk("rb_d_rvalid", a_d_rvalid, 1);
        chk("rb_d_rdata", a_d_rdata, 32'hDEADBEEF);
        chk("rb_i_rvalid", a_i_rvalid, 0);
        // starvation bound: D,D,D,D,I repeating
        nxt(); a_i_req = 1'b1; a_i_addr = 16'h0004; a_d_req = 1'b1; a_d_addr = 16'h0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("stv_i_gnt%0d", k), a_i_gnt, (k % 5 == 4) ? 1 : 0);
            chk($sformatf("stv_d_gnt%0d", k), a_d_gnt, (k % 5 == 4) ? 0 : 1);
            nxt();
        end
        a_i_req = 1'b0; a_d_req = 1'b0;
        // latency 3, back-to-back reads
        b_d_req = 1'b1; b_d_addr = 16'h0010;
        @(negedge clk);
        chk("lat_T_d_gnt", b_d_gnt, 1);
        chk("lat_T_mem_en", b_mem_en, 1);
        nxt(); b_d_addr = 16'h0011;
        @(negedge clk);
        chk("lat_T1_d_gnt", b_d_gnt, 0);
        chk("lat_T1_mem_en", b_mem_en, 0);
        nxt();
        @(negedge clk);
        chk("lat_T2_mem_en", b_mem_en, 0);
        chk("lat_T2_d_rvalid", b_d_rvalid, 0);
        nxt();
        @(negedge clk);
        chk("lat_T3_d_rvalid", b_d_rvalid, 1);
        chk("lat_T3_d_rdata", b_d_rdata, 32'hA0000010);
        chk("lat_T3_d_gnt", b_d_gnt, 1);
        chk("lat_T3_mem_addr", b_mem_addr, 32'h0011);
        nxt(); b_d_req = 1'b0;
        @(negedge clk);
        chk("lat_T4_d_rvalid", b_d_rvalid, 0);
        nxt();
        nxt();
        @(negedge clk);
        chk("lat_T6_d_rvalid", b_d_rvalid, 1);
        chk("lat_T6_d_rdata", b_d_rdata, 32'hA0000011);
        // reset in the middle of an access
        nxt(); b_d_req = 1'b1; b_d_addr = 16'h0010;
        @(negedge clk);
        chk("mrst_d_gnt", b_d_gnt, 1);
        nxt(); b_d_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("mrst_d_rvalid", b_d_rvalid, 0);
        chk("mrst_mem_en", b_mem_en, 0);
        nxt();
        nxt(); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mrst_post_d_rvalid%0d", k), b_d_rvalid, 0);
            chk($sformatf("mrst_post_i_rvalid%0d", k), b_i_rvalid, 0);
            nxt();
        end
        b_d_req = 1'b1; b_d_addr = 16'h0011;
        @(negedge clk);
        chk("mrst_new_d_gnt", b_d_gnt, 1);
        nxt(); b_d_req = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        chk("mrst_new_d_rvalid", b_d_rvalid, 1);
        chk("mrst_new_d_rdata", b_d_rdata, 32'hA0000011);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
